// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard interface: decoded D-stage fields and flush in; stall, MDU busy and
// stall-cycle count out.
interface hazard_scoreboard_if #(
  parameter int TW   = 3,
  parameter int CNTW = 16
);
  logic [4:0]      D_rs;
  logic [4:0]      D_rt;
  logic [TW-1:0]   Tuse_rs;
  logic [TW-1:0]   Tuse_rt;
  logic [4:0]      D_RegAddr;
  logic [TW-1:0]   D_Tnew;
  logic            D_CP0Write;
  logic [4:0]      D_rd;
  logic            D_eret;
  logic            D_HILO;
  logic            D_MDStart;
  logic            D_MDDiv;
  logic            flush;
  logic            Stall;
  logic            Busy;
  logic [CNTW-1:0] StallCnt;

  modport master (
    output D_rs, D_rt, Tuse_rs, Tuse_rt, D_RegAddr, D_Tnew, D_CP0Write, D_rd,
           D_eret, D_HILO, D_MDStart, D_MDDiv, flush,
    input  Stall, Busy, StallCnt
  );

  modport slave (
    input  D_rs, D_rt, Tuse_rs, Tuse_rt, D_RegAddr, D_Tnew, D_CP0Write, D_rd,
           D_eret, D_HILO, D_MDStart, D_MDDiv, flush,
    output Stall, Busy, StallCnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// D-stage stall unit: tracks in-flight destinations/Tnew, MDU busy countdown and
// pending EPC writes, and raises a combinational stall plus a saturating stall count.
module hazard_scoreboard #(
  parameter int NSTAGE   = 2,
  parameter int TW       = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int EPC_ADDR = 14,
  parameter int CNTW     = 16
) (
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave bus
);
  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int MDW    = $clog2(MD_MAX + 1);

  typedef struct packed {
    logic [4:0]    addr;
    logic [TW-1:0] tnew;
    logic          cp0w;
    logic [4:0]    cp0rd;
  } entry_t;

  entry_t [NSTAGE:1] ent, ent_nxt;
  logic   [NSTAGE:1] gpr_hit, cp0_hit;
  logic   [MDW-1:0]  md_cnt;
  logic   [CNTW-1:0] stall_cnt;
  logic              busy, stall, md_load;

  // Each stage is compared on its own; a bubble (addr 0) can never match since rs/rt 0 is excluded.
  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    assign gpr_hit[k] =
      (bus.D_rs != 5'd0 && bus.D_rs == ent[k].addr && bus.Tuse_rs < ent[k].tnew) ||
      (bus.D_rt != 5'd0 && bus.D_rt == ent[k].addr && bus.Tuse_rt < ent[k].tnew);
    assign cp0_hit[k] = ent[k].cp0w && (ent[k].cp0rd == 5'(EPC_ADDR));
  end

  assign busy    = (md_cnt != '0);
  assign stall   = (|gpr_hit) || (bus.D_eret && (|cp0_hit)) ||
                   ((bus.D_HILO || bus.D_MDStart) && busy);
  assign md_load = bus.D_MDStart && !stall && !bus.flush;

  assign bus.Stall    = stall;
  assign bus.Busy     = busy;
  assign bus.StallCnt = stall_cnt;

  // Next scoreboard: flush empties everything, a stall injects a bubble into E.
  always_comb begin
    ent_nxt = '0;
    if (!bus.flush) begin
      if (!stall) begin
        ent_nxt[1].addr  = bus.D_RegAddr;
        ent_nxt[1].tnew  = bus.D_Tnew;
        ent_nxt[1].cp0w  = bus.D_CP0Write;
        ent_nxt[1].cp0rd = bus.D_rd;
      end
      for (int k = 2; k <= NSTAGE; k++) begin
        ent_nxt[k] = ent[k-1];
        if (ent[k-1].tnew != '0) ent_nxt[k].tnew = ent[k-1].tnew - TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent       <= '0;
      md_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      ent <= ent_nxt;
      // A running MDU count survives flush; only the load itself is suppressed.
      if (md_load)
        md_cnt <= bus.D_MDDiv ? MDW'(DIV_CYC) : MDW'(MULT_CYC);
      else if (busy)
        md_cnt <= md_cnt - MDW'(1);
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: default build and an NSTAGE=3/CNTW=2 build driven in lockstep,
// both checked every cycle against an in-flight-instruction reference model.
module tb_hazard_scoreboard;
  logic clk;
  logic reset;

  hazard_scoreboard_if #(.TW(3), .CNTW(16)) bus0 ();
  hazard_scoreboard_if #(.TW(3), .CNTW(2))  bus1 ();

  hazard_scoreboard #(.NSTAGE(2), .TW(3), .CNTW(16)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  hazard_scoreboard #(.NSTAGE(3), .TW(3), .CNTW(2))  dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int tnew;
    bit cp0w;
    int rd;
  } inst_t;

  typedef struct {
    int rs, rt, tuse_rs, tuse_rt, regaddr, tnew, rd;
    bit cp0w, eret, hilo, mdstart, mddiv, flush;
  } drv_t;

  drv_t  cur;
  inst_t hist0[$];   // instructions that entered E, newest first
  inst_t hist1[$];
  int    md_start[2];
  int    md_len[2];
  int    scnt[2];
  int    cyc;
  int    tests;
  int    fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_busy(input int i);
    return (cyc - md_start[i]) < md_len[i];
  endfunction

  // Stall from the rules: the instruction 'a' stages past E has Tnew reduced by a (floor 0).
  function automatic bit m_stall(input int i);
    inst_t h[$];
    int    ns;
    bit    hit;
    if (i == 0) begin h = hist0; ns = 2; end
    else        begin h = hist1; ns = 3; end
    hit = (cur.hilo || cur.mdstart) && m_busy(i);
    for (int a = 0; a < h.size() && a < ns; a++) begin
      int left;
      left = h[a].tnew - a;
      if (left < 0) left = 0;
      if (cur.rs != 0 && cur.rs == h[a].addr && cur.tuse_rs < left) hit = 1;
      if (cur.rt != 0 && cur.rt == h[a].addr && cur.tuse_rt < left) hit = 1;
      if (cur.eret && h[a].cp0w && h[a].rd == 14) hit = 1;
    end
    return hit;
  endfunction

  function automatic void m_update(input int i, input bit s);
    inst_t h[$];
    inst_t e;
    int    ns, smax;
    if (i == 0) begin h = hist0; ns = 2; smax = 65535; end
    else        begin h = hist1; ns = 3; smax = 3;     end
    if (reset) begin
      h.delete();
      md_len[i] = 0;
      scnt[i]   = 0;
    end else begin
      if (s && scnt[i] < smax) scnt[i]++;
      if (cur.flush) h.delete();
      else begin
        e.addr = 0; e.tnew = 0; e.cp0w = 0; e.rd = 0;
        if (!s) begin
          e.addr = cur.regaddr; e.tnew = cur.tnew; e.cp0w = cur.cp0w; e.rd = cur.rd;
        end
        h.push_front(e);
        while (h.size() > ns) void'(h.pop_back());
      end
      if (cur.mdstart && !s && !cur.flush) begin
        md_start[i] = cyc;
        md_len[i]   = cur.mddiv ? 10 : 5;
      end
    end
    if (i == 0) hist0 = h; else hist1 = h;
  endfunction

  task automatic apply();
    bus0.D_rs = 5'(cur.rs);           bus1.D_rs = 5'(cur.rs);
    bus0.D_rt = 5'(cur.rt);           bus1.D_rt = 5'(cur.rt);
    bus0.Tuse_rs = 3'(cur.tuse_rs);   bus1.Tuse_rs = 3'(cur.tuse_rs);
    bus0.Tuse_rt = 3'(cur.tuse_rt);   bus1.Tuse_rt = 3'(cur.tuse_rt);
    bus0.D_RegAddr = 5'(cur.regaddr); bus1.D_RegAddr = 5'(cur.regaddr);
    bus0.D_Tnew = 3'(cur.tnew);       bus1.D_Tnew = 3'(cur.tnew);
    bus0.D_CP0Write = cur.cp0w;       bus1.D_CP0Write = cur.cp0w;
    bus0.D_rd = 5'(cur.rd);           bus1.D_rd = 5'(cur.rd);
    bus0.D_eret = cur.eret;           bus1.D_eret = cur.eret;
    bus0.D_HILO = cur.hilo;           bus1.D_HILO = cur.hilo;
    bus0.D_MDStart = cur.mdstart;     bus1.D_MDStart = cur.mdstart;
    bus0.D_MDDiv = cur.mddiv;         bus1.D_MDDiv = cur.mddiv;
    bus0.flush = cur.flush;           bus1.flush = cur.flush;
  endtask

  task automatic idle();
    cur.rs = 0; cur.rt = 0; cur.tuse_rs = 0; cur.tuse_rt = 0; cur.regaddr = 0;
    cur.tnew = 0; cur.rd = 0; cur.cp0w = 0; cur.eret = 0; cur.hilo = 0;
    cur.mdstart = 0; cur.mddiv = 0; cur.flush = 0;
  endtask

  // One clock: drive, check mid-cycle against the model, clock, advance the model.
  task automatic step(input bit check);
    bit s0, s1;
    apply();
    #2;
    s0 = m_stall(0);
    s1 = m_stall(1);
    if (check) begin
      chk("stall0", 32'(bus0.Stall), 32'(s0));
      chk("busy0", 32'(bus0.Busy), 32'(m_busy(0)));
      chk("cnt0", 32'(bus0.StallCnt), 32'(scnt[0]));
      chk("stall1", 32'(bus1.Stall), 32'(s1));
      chk("busy1", 32'(bus1.Busy), 32'(m_busy(1)));
      chk("cnt1", 32'(bus1.StallCnt), 32'(scnt[1]));
    end
    @(posedge clk);
    cyc++;
    m_update(0, s0);
    m_update(1, s1);
    #1;
  endtask

  int n;

  initial begin
    tests = 0; fails = 0; cyc = 0;
    md_start = '{0, 0}; md_len = '{0, 0}; scnt = '{0, 0};

    // reset with inputs that would otherwise look like hazards
    idle(); reset = 1'b1; cur.rs = 5; cur.hilo = 1;
    step(0); step(1);
    reset = 1'b0;
    step(1);
    chk("rst_cnt0", 32'(bus0.StallCnt), 32'd0);

    // lw $8 then dependent addu
    idle(); cur.regaddr = 8; cur.tnew = 2; step(1);
    idle(); cur.rs = 8; cur.tuse_rs = 1; step(1); step(1); step(1);

    // div then mflo: Busy for exactly 10 cycles; then mult: 5 cycles
    idle(); cur.mdstart = 1; cur.mddiv = 1; step(1);
    idle(); cur.hilo = 1; n = 0;
    repeat (12) begin if (bus0.Busy === 1'b1) n++; step(1); end
    chk("div_busy_len", 32'(n), 32'd10);
    chk("sat_cnt1", 32'(bus1.StallCnt), 32'd3);
    idle(); cur.mdstart = 1; step(1);
    idle(); cur.hilo = 1; n = 0;
    repeat (7) begin if (bus0.Busy === 1'b1) n++; step(1); end
    chk("mult_busy_len", 32'(n), 32'd5);

    // mtc0 EPC then eret stalls; mtc0 to another register does not
    idle(); cur.cp0w = 1; cur.rd = 14; step(1);
    idle(); cur.eret = 1; repeat (5) step(1);
    idle(); cur.cp0w = 1; cur.rd = 12; step(1);
    idle(); cur.eret = 1; repeat (3) step(1);

    // flush kills a pending load
    idle(); cur.regaddr = 8; cur.tnew = 2; step(1);
    idle(); cur.rs = 8; cur.flush = 1; step(1);
    cur.flush = 0; step(1); step(1);

    // Tnew 3 producer, Tuse 0 consumer: 3-stage build stalls 3 cycles
    idle(); cur.regaddr = 9; cur.tnew = 3; step(1);
    idle(); cur.rt = 9; repeat (5) step(1);

    // flush during a running divide does not cancel it
    idle(); cur.mdstart = 1; cur.mddiv = 1; step(1);
    idle(); cur.flush = 1; step(1);
    idle(); cur.hilo = 1; repeat (11) step(1);

    // randomized traffic with small register range to provoke hazards
    repeat (400) begin
      idle();
      reset        = ($urandom_range(0, 63) == 0);
      cur.rs       = $urandom_range(0, 3);
      cur.rt       = $urandom_range(0, 3);
      cur.tuse_rs  = $urandom_range(0, 3);
      cur.tuse_rt  = $urandom_range(0, 3);
      cur.regaddr  = $urandom_range(0, 3);
      cur.tnew     = $urandom_range(0, 4);
      cur.cp0w     = ($urandom_range(0, 3) == 0);
      cur.rd       = ($urandom_range(0, 1) == 0) ? 14 : 12;
      cur.eret     = ($urandom_range(0, 4) == 0);
      cur.hilo     = ($urandom_range(0, 5) == 0);
      cur.mdstart  = ($urandom_range(0, 7) == 0);
      cur.mddiv    = ($urandom_range(0, 1) == 0);
      cur.flush    = ($urandom_range(0, 15) == 0);
      step(1);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation D-stage stall unit for the MIPS pipeline. It owns its own scoreboard of in-flight destination registers and Tnew values across NSTAGE downstream stages (stage 1 = E). It also owns the multiply/divide busy countdown, EPC-write tracking for eret, and a saturating stall-cycle counter.
- Sits beside the D/E pipeline register. Its Stall output freezes PC/F/D and inserts an E bubble. Its flush input is driven by the exception/eret logic.

Parameters:
- NSTAGE, 2, number of downstream stages tracked (E, M, …); minimum 1.
- TW, 3, width of Tuse/Tnew fields.
- MULT_CYC, 5, busy cycles for mult/multu/mthi/mtlo-class starts.
- DIV_CYC, 10, busy cycles for div/divu starts.
- EPC_ADDR, 14, CP0 register number of EPC.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- D_rs  in  5  rs of the instruction in D.
- D_rt  in  5  rt of the instruction in D.
- Tuse_rs  in  TW  cycles until D needs rs.
- Tuse_rt  in  TW  cycles until D needs rt.
- D_RegAddr  in  5  GPR destination of D (0 = none).
- D_Tnew  in  TW  Tnew of D's result once it is in E.
- D_CP0Write  in  1  D is mtc0.
- D_rd  in  5  CP0 register written by D.
- D_eret  in  1  D is eret.
- D_HILO  in  1  D reads or writes HI/LO, including mult/div.
- D_MDStart  in  1  D starts the MDU.
- D_MDDiv  in  1  qualifies D_MDStart: 1 = divide.
- flush  in  1  kill all tracked instructions (exception/eret).
- Stall  out  1  combinational stall request to D.
- Busy  out  1  MDU busy (md_cnt != 0).
- StallCnt  out  CNTW  saturating count of stalled cycles.

Behaviour:
- State:
  - Entries k=1..NSTAGE, each {addr[5], tnew[TW], cp0w, cp0rd[5]}.
  - md_cnt, width ceil(log2(max(MULT_CYC,DIV_CYC)+1)).
  - StallCnt.
- Reset, which has priority over everything: all entries = bubble (addr=0, tnew=0, cp0w=0, cp0rd=0); md_cnt=0; StallCnt=0. Consequence: Stall=0 and Busy=0 in the cycle after reset regardless of inputs.
- Scoreboard advance, every cycle when not reset:
  - If flush: every entry <= bubble. No advance or insert.
  - Else:
    - Entry k+1 <= entry k, with tnew decremented and saturating at 0.
    - Entry 1 <= bubble if Stall, else {D_RegAddr, D_Tnew, D_CP0Write, D_rd}.
  - The oldest entry NSTAGE is discarded on advance.
- GPR stall, combinational:
  - Fires for any k where (D_rs==addr[k] && D_rs!=0 && Tuse_rs<tnew[k]) or the same condition for rt.
  - Every stage is checked independently; no priority.
  - tnew=0 never stalls.
- HILO stall: (D_HILO || D_MDStart) && Busy.
- CP0 stall: D_eret && any k with cp0w[k] && cp0rd[k]==EPC_ADDR.
- Stall = OR of the GPR, HILO and CP0 stalls.
- MDU counter:
  - On posedge with D_MDStart && !Stall && !flush: md_cnt <= D_MDDiv ? DIV_CYC : MULT_CYC.
  - Else if md_cnt!=0: decrement by 1.
  - Busy is therefore 1 for exactly MULT_CYC/DIV_CYC cycles, starting the cycle the op is in E.
  - flush does not cancel a running count; flush in the load cycle suppresses the load.
- StallCnt: increments on each posedge where Stall=1; holds at 2^CNTW-1; is not cleared by flush.
- A stall and a flush in the same cycle: flush wins for scoreboard state. StallCnt still counts the cycle.
- No X propagation: a bubble has addr=0, so it can never match a valid register.

Test Plan:
- reset=1 for 2 cycles with D_rs=5, D_HILO=1 -> Stall=0, Busy=0, StallCnt=0 after reset.
- Load lw $8 (D_RegAddr=8, D_Tnew=2), next D addu using rs=8 with Tuse_rs=1 -> Stall=1 for 1 cycle (tnew 2 in E), Stall=0 next cycle (tnew 1 in M); StallCnt=1.
- D_MDStart=1, D_MDDiv=1, then D_HILO=1 (mflo) -> Busy=1 for 10 consecutive cycles, Stall=1 for those 10 cycles, mflo issues the cycle Busy falls; same sequence with MULT -> 5 cycles.
- mtc0 $14 (D_CP0Write=1, D_rd=14), then eret -> Stall=1 for NSTAGE cycles (2 by default), then 0; repeat with D_rd=12 -> Stall=0.
- Pending lw $8 in E, assert flush, then addu rs=8 Tuse_rs=0 -> no stall after flush (all entries bubble).
- CNTW=2, force 5 consecutive stall cycles -> StallCnt sequence 1,2,3,3,3; NSTAGE=3 build: producer with D_Tnew=3 and consumer Tuse=0 -> stall 3 cycles.
